// File: rtl/gpio_cmd_responder.sv
// rtl/gpio_cmd_responder.sv - GPIO-word command decoder and responder; optional GPIO_CMD_ERR_EN flags unknown opcodes
module gpio_cmd_responder #(
    parameter int NB_GPIOS        = 32,
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int NB_BER          = 64,
    parameter int BRAM_LAT        = 2
) (
    input  logic                       clk100,
    input  logic                       i_rst,
    input  logic [NB_GPIOS-1:0]        i_gpo,
    output logic [NB_GPIOS-1:0]        o_gpi,
    output logic                       o_rst,
    output logic                       o_enb_tx,
    output logic                       o_enb_rx,
    output logic [1:0]                 o_phase_sel,
    output logic                       o_run_log,
    output logic                       o_read_log,
    output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log,
    output logic                       o_mem_rd,
    input  logic [BRAM_DATA_WIDTH-1:0] i_mem_data,
    input  logic                       i_mem_full,
    input  logic [NB_BER-1:0]          i_ber_samp_i,
    input  logic [NB_BER-1:0]          i_ber_samp_q,
    input  logic [NB_BER-1:0]          i_ber_err_i,
    input  logic [NB_BER-1:0]          i_ber_err_q,
    output logic                       o_cmd_err
);
    localparam int SNAP_W = (NB_BER > 64) ? NB_BER : 64;

    localparam logic [7:0] OP_RESET    = 8'd0;
    localparam logic [7:0] OP_EN_TX    = 8'd1;
    localparam logic [7:0] OP_EN_RX    = 8'd2;
    localparam logic [7:0] OP_PH_SEL   = 8'd3;
    localparam logic [7:0] OP_RUN_MEM  = 8'd4;
    localparam logic [7:0] OP_READ_MEM = 8'd5;
    localparam logic [7:0] OP_ADDR_MEM = 8'd6;
    localparam logic [7:0] OP_BER_S_I  = 8'd7;
    localparam logic [7:0] OP_BER_S_Q  = 8'd8;
    localparam logic [7:0] OP_BER_E_I  = 8'd9;
    localparam logic [7:0] OP_BER_E_Q  = 8'd10;
    localparam logic [7:0] OP_BER_H    = 8'd11;
    localparam logic [7:0] OP_MEM_FULL = 8'd12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DECODE   = 2'd1,
        ST_WAIT_MEM = 2'd2
    } state_t;

    state_t                       state_q;
    logic [NB_GPIOS-1:0]          gpo_q;
    logic                         enb_prev_q;
    logic                         rst_dly_q;
    logic [7:0]                   op_q;
    logic [22:0]                  data_q;
    logic [3:0]                   cnt_q;
    logic [NB_GPIOS-1:0]          gpi_q;
    logic                         rst_q;
    logic                         enb_tx_q;
    logic                         enb_rx_q;
    logic [1:0]                   phase_q;
    logic                         run_log_q;
    logic                         read_log_q;
    logic [BRAM_ADDR_WIDTH-1:0]   addr_q;
    logic                         mem_rd_q;
    logic [NB_BER-1:0]            snap_q;
    logic [NB_BER-1:0]            ber_sel;
    logic [SNAP_W-1:0]            snap_w;
    logic                         cmd_edge;
    logic                         unused_bits;

    assign snap_w      = SNAP_W'(snap_q);
    assign cmd_edge    = gpo_q[23] & ~enb_prev_q;
    assign unused_bits = ^{data_q, snap_w, gpo_q};

    assign o_gpi       = gpi_q;
    assign o_rst       = rst_q;
    assign o_enb_tx    = enb_tx_q;
    assign o_enb_rx    = enb_rx_q;
    assign o_phase_sel = phase_q;
    assign o_run_log   = run_log_q;
    assign o_read_log  = read_log_q;
    assign o_addr_log  = addr_q;
    assign o_mem_rd    = mem_rd_q;

`ifdef GPIO_CMD_ERR_EN
    logic cmd_err_q;
    assign o_cmd_err = cmd_err_q;
`else
    assign o_cmd_err = 1'b0;
`endif

    // Register the GPO word; the first post-reset cycle forces the history high so a held enable is not an edge
    always_ff @(posedge clk100) begin
        if (i_rst) begin
            gpo_q      <= '0;
            enb_prev_q <= 1'b1;
            rst_dly_q  <= 1'b1;
        end else begin
            gpo_q      <= i_gpo;
            enb_prev_q <= rst_dly_q | gpo_q[23];
            rst_dly_q  <= 1'b0;
        end
    end

    // Select the BER counter addressed by the latched opcode
    always_comb begin
        ber_sel = '0;
        case (op_q)
            OP_BER_S_I: ber_sel = i_ber_samp_i;
            OP_BER_S_Q: ber_sel = i_ber_samp_q;
            OP_BER_E_I: ber_sel = i_ber_err_i;
            OP_BER_E_Q: ber_sel = i_ber_err_q;
            default:    ber_sel = '0;
        endcase
    end

    // Command FSM: accept in IDLE, execute in DECODE, wait out the memory latency for reads
    always_ff @(posedge clk100) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            gpi_q      <= '0;
            rst_q      <= 1'b0;
            enb_tx_q   <= 1'b0;
            enb_rx_q   <= 1'b0;
            phase_q    <= '0;
            run_log_q  <= 1'b0;
            read_log_q <= 1'b0;
            addr_q     <= '0;
            mem_rd_q   <= 1'b0;
            snap_q     <= '0;
`ifdef GPIO_CMD_ERR_EN
            cmd_err_q  <= 1'b0;
`endif
        end else begin
            run_log_q <= 1'b0;
            mem_rd_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_edge) begin
                        op_q    <= gpo_q[31:24];
                        data_q  <= gpo_q[22:0];
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_q <= ST_IDLE;
                    case (op_q)
                        OP_RESET: begin
                            rst_q <= data_q[0];
`ifdef GPIO_CMD_ERR_EN
                            cmd_err_q <= 1'b0;
`endif
                        end
                        OP_EN_TX:  enb_tx_q <= data_q[0];
                        OP_EN_RX:  enb_rx_q <= data_q[0];
                        OP_PH_SEL: phase_q  <= data_q[1:0];
                        OP_RUN_MEM: begin
                            run_log_q  <= 1'b1;
                            read_log_q <= 1'b0;
                        end
                        OP_READ_MEM, OP_ADDR_MEM: begin
                            read_log_q <= 1'b1;
                            addr_q     <= data_q[BRAM_ADDR_WIDTH-1:0];
                            mem_rd_q   <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= ST_WAIT_MEM;
                        end
                        OP_BER_S_I, OP_BER_S_Q, OP_BER_E_I, OP_BER_E_Q: begin
                            snap_q <= ber_sel;
                            gpi_q  <= NB_GPIOS'(ber_sel[31:0]);
                        end
                        OP_BER_H:    gpi_q <= NB_GPIOS'(snap_w[63:32]);
                        OP_MEM_FULL: gpi_q <= NB_GPIOS'(i_mem_full);
                        default: begin
`ifdef GPIO_CMD_ERR_EN
                            gpi_q     <= NB_GPIOS'({8'hFF, op_q, 16'h0000});
                            cmd_err_q <= 1'b1;
`endif
                        end
                    endcase
                end
                ST_WAIT_MEM: begin
                    // cnt_q counts cycles since the read strobe; data is valid BRAM_LAT cycles after it
                    if (cnt_q == 4'(BRAM_LAT)) begin
                        gpi_q   <= NB_GPIOS'(i_mem_data);
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_cmd_responder.sv
// tb/tb_gpio_cmd_responder.sv - randomized self-checking bench for gpio_cmd_responder
module tb_gpio_cmd_responder;
    localparam int LAT = 2;

    logic        clk100 = 1'b0;
    logic        i_rst;
    logic [31:0] i_gpo;
    logic [31:0] o_gpi;
    logic        o_rst, o_enb_tx, o_enb_rx, o_run_log, o_read_log, o_mem_rd, o_cmd_err;
    logic [1:0]  o_phase_sel;
    logic [14:0] o_addr_log;
    logic [15:0] i_mem_data;
    logic        i_mem_full;
    logic [63:0] i_ber_samp_i, i_ber_samp_q, i_ber_err_i, i_ber_err_q;

    always #5 clk100 = ~clk100;

    gpio_cmd_responder #(
        .NB_GPIOS(32), .BRAM_ADDR_WIDTH(15), .BRAM_DATA_WIDTH(16), .NB_BER(64), .BRAM_LAT(LAT)
    ) dut (
        .clk100(clk100), .i_rst(i_rst), .i_gpo(i_gpo), .o_gpi(o_gpi),
        .o_rst(o_rst), .o_enb_tx(o_enb_tx), .o_enb_rx(o_enb_rx), .o_phase_sel(o_phase_sel),
        .o_run_log(o_run_log), .o_read_log(o_read_log), .o_addr_log(o_addr_log),
        .o_mem_rd(o_mem_rd), .i_mem_data(i_mem_data), .i_mem_full(i_mem_full),
        .i_ber_samp_i(i_ber_samp_i), .i_ber_samp_q(i_ber_samp_q),
        .i_ber_err_i(i_ber_err_i), .i_ber_err_q(i_ber_err_q), .o_cmd_err(o_cmd_err)
    );

    int n_pass = 0;
    int n_total = 0;
    int run_cnt = 0;
    int rd_cnt = 0;

    // reference model state
    logic [31:0] m_gpi;
    logic        m_rst, m_tx, m_rx, m_read, m_latched, m_err;
    logic [1:0]  m_ph;
    logic [14:0] m_addr;
    logic [63:0] m_snap;
    int          m_runs = 0;
    int          m_rds = 0;

    function automatic logic [15:0] mem_f(input logic [14:0] a);
        logic [15:0] v;
        v = {1'b0, a} * 16'd7 + 16'h1234;
        if (a == 15'd10) v = 16'hABCD;
        return v;
    endfunction

    // memory with LAT-cycle read latency; garbage outside the valid cycle
    logic [7:0]       pv = '0;
    logic [7:0][15:0] pd = '0;
    always @(posedge clk100) begin
        pv <= {pv[6:0], o_mem_rd};
        pd <= {pd[6:0], mem_f(o_addr_log)};
    end
    assign i_mem_data = pv[LAT-1] ? pd[LAT-1] : 16'hDEAD;

    always @(posedge clk100) begin
        if (o_run_log) run_cnt <= run_cnt + 1;
        if (o_mem_rd)  rd_cnt  <= rd_cnt + 1;
    end

    task automatic model_reset();
        m_gpi = '0; m_rst = 0; m_tx = 0; m_rx = 0; m_read = 0; m_latched = 0; m_err = 0;
        m_ph = '0; m_addr = '0; m_snap = '0;
    endtask

    task automatic model_apply(input logic [7:0] op, input logic [22:0] d);
        logic [63:0] sel;
        if (op == 0) begin m_rst = d[0]; m_err = 0; end
        else if (op == 1) m_tx = d[0];
        else if (op == 2) m_rx = d[0];
        else if (op == 3) m_ph = d[1:0];
        else if (op == 4) begin m_read = 0; m_runs++; end
        else if (op == 5 || op == 6) begin
            m_read = 1; m_addr = d[14:0]; m_gpi = {16'h0, mem_f(d[14:0])}; m_rds++;
        end else if (op >= 7 && op <= 10) begin
            sel = (op == 7) ? i_ber_samp_i : (op == 8) ? i_ber_samp_q : (op == 9) ? i_ber_err_i : i_ber_err_q;
            m_snap = sel; m_latched = 1; m_gpi = sel[31:0];
        end else if (op == 11) m_gpi = m_latched ? m_snap[63:32] : 32'h0;
        else if (op == 12) m_gpi = {31'b0, i_mem_full};
        else begin
`ifdef GPIO_CMD_ERR_EN
            m_gpi = {8'hFF, op, 16'h0000}; m_err = 1;
`endif
        end
    endtask

    // returns at the negedge just after the edge that sampled the enable high
    task automatic pulse_enable(input logic [7:0] op, input logic [22:0] d);
        @(negedge clk100); i_gpo = {op, 1'b1, d};
        @(negedge clk100); i_gpo[23] = 1'b0;
    endtask

    task automatic send(input logic [7:0] op, input logic [22:0] d);
        model_apply(op, d);
        pulse_enable(op, d);
        repeat ((op == 5 || op == 6) ? (3 + LAT) : 2) @(posedge clk100);
        @(negedge clk100);
    endtask

    task automatic test_reset();
        i_rst = 1; i_gpo = $urandom; i_mem_full = 1;
        repeat (3) @(posedge clk100);
        @(negedge clk100);
        n_total++; if (o_gpi !== 32'h0) $display("FAIL reset_gpi: got %h exp 0", o_gpi); else n_pass++;
        n_total++; if ({o_rst, o_enb_tx, o_enb_rx, o_phase_sel, o_run_log, o_read_log, o_mem_rd, o_cmd_err} !== 9'h0)
            $display("FAIL reset_ctrl: got %b exp 0", {o_rst, o_enb_tx, o_enb_rx, o_phase_sel, o_run_log, o_read_log, o_mem_rd, o_cmd_err});
        else n_pass++;
        n_total++; if (o_addr_log !== 15'h0) $display("FAIL reset_addr: got %h exp 0", o_addr_log); else n_pass++;
        i_gpo = '0; i_mem_full = 0; model_reset();
        @(negedge clk100); i_rst = 0;
        repeat (2) @(negedge clk100);
    endtask

    task automatic test_ph_sel_timing();
        model_apply(8'd3, 23'd2);
        pulse_enable(8'd3, 23'd2);
        @(posedge clk100); @(negedge clk100);
        n_total++; if (o_phase_sel !== 2'd0) $display("FAIL ph_early: got %0d exp 0", o_phase_sel); else n_pass++;
        @(posedge clk100); @(negedge clk100);
        n_total++; if (o_phase_sel !== 2'd2) $display("FAIL ph_sel: got %0d exp 2", o_phase_sel); else n_pass++;
        n_total++; if (o_gpi !== 32'h0) $display("FAIL ph_gpi: got %h exp 0", o_gpi); else n_pass++;
        send(8'd11, 23'd0);
        n_total++; if (o_gpi !== 32'h0) $display("FAIL berh_none: got %h exp 0", o_gpi); else n_pass++;
    endtask

    task automatic test_ber();
        i_ber_err_i = 64'h0000_0005_0000_0009;
        send(8'd9, 23'd0);
        n_total++; if (o_gpi !== 32'h9) $display("FAIL ber_lo: got %h exp 9", o_gpi); else n_pass++;
        send(8'd11, 23'd0);
        n_total++; if (o_gpi !== 32'h5) $display("FAIL ber_hi: got %h exp 5", o_gpi); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            i_ber_samp_i = {$urandom, $urandom}; i_ber_samp_q = {$urandom, $urandom};
            i_ber_err_i = {$urandom, $urandom};  i_ber_err_q = {$urandom, $urandom};
            send(8'(7 + k), 23'($urandom));
            n_total++; if (o_gpi !== m_gpi) $display("FAIL ber_lo_%0d: got %h exp %h", k, o_gpi, m_gpi); else n_pass++;
            i_ber_samp_i = {$urandom, $urandom}; i_ber_err_q = {$urandom, $urandom};
            send(8'd11, 23'd0);
            n_total++; if (o_gpi !== m_gpi) $display("FAIL ber_hi_%0d: got %h exp %h", k, o_gpi, m_gpi); else n_pass++;
        end
    endtask

    task automatic test_read_mem();
        logic [31:0] prev;
        int r0;
        prev = m_gpi; r0 = rd_cnt;
        model_apply(8'd5, 23'd10);
        pulse_enable(8'd5, 23'd10);
        repeat (2) @(posedge clk100); @(negedge clk100);
        n_total++; if (o_addr_log !== 15'd10) $display("FAIL rd_addr: got %0d exp 10", o_addr_log); else n_pass++;
        n_total++; if (o_read_log !== 1'b1) $display("FAIL rd_read_log: got %b exp 1", o_read_log); else n_pass++;
        n_total++; if (o_mem_rd !== 1'b1) $display("FAIL rd_strobe: got %b exp 1", o_mem_rd); else n_pass++;
        repeat (LAT) @(posedge clk100); @(negedge clk100);
        n_total++; if (o_gpi !== prev) $display("FAIL rd_early: got %h exp %h", o_gpi, prev); else n_pass++;
        @(posedge clk100); @(negedge clk100);
        n_total++; if (o_gpi !== 32'h0000ABCD) $display("FAIL rd_data: got %h exp 0000abcd", o_gpi); else n_pass++;
        n_total++; if (rd_cnt !== r0 + 1) $display("FAIL rd_pulses: got %0d exp %0d", rd_cnt - r0, 1); else n_pass++;
    endtask

    task automatic test_drop();
        logic [14:0] a;
        int r0;
        a = 15'($urandom); r0 = rd_cnt;
        model_apply(8'd6, {8'd0, a});
        pulse_enable(8'd6, {8'd0, a});
        repeat (2) @(posedge clk100);
        @(negedge clk100); i_gpo = {8'd3, 1'b1, 23'd3};
        @(negedge clk100); i_gpo[23] = 1'b0;
        repeat (LAT) @(posedge clk100); @(negedge clk100);
        n_total++; if (o_gpi !== m_gpi) $display("FAIL drop_data: got %h exp %h", o_gpi, m_gpi); else n_pass++;
        repeat (6) @(negedge clk100);
        n_total++; if (o_phase_sel !== m_ph) $display("FAIL drop_ph: got %0d exp %0d", o_phase_sel, m_ph); else n_pass++;
        n_total++; if (o_gpi !== m_gpi) $display("FAIL drop_hold: got %h exp %h", o_gpi, m_gpi); else n_pass++;
        n_total++; if (rd_cnt !== r0 + 1) $display("FAIL drop_pulses: got %0d exp 1", rd_cnt - r0); else n_pass++;
    endtask

    task automatic test_mem_full_run();
        int r0;
        i_mem_full = 1;
        send(8'd12, 23'd0);
        n_total++; if (o_gpi !== 32'h1) $display("FAIL mem_full: got %h exp 1", o_gpi); else n_pass++;
        i_mem_full = 0;
        r0 = run_cnt;
        model_apply(8'd4, 23'd0);
        pulse_enable(8'd4, 23'd0);
        repeat (2) @(posedge clk100); @(negedge clk100);
        n_total++; if (o_run_log !== 1'b1) $display("FAIL run_pulse: got %b exp 1", o_run_log); else n_pass++;
        n_total++; if (o_read_log !== 1'b0) $display("FAIL run_read_log: got %b exp 0", o_read_log); else n_pass++;
        @(posedge clk100); @(negedge clk100);
        n_total++; if (o_run_log !== 1'b0) $display("FAIL run_width: got %b exp 0", o_run_log); else n_pass++;
        repeat (3) @(negedge clk100);
        n_total++; if (run_cnt !== r0 + 1) $display("FAIL run_count: got %0d exp 1", run_cnt - r0); else n_pass++;
        n_total++; if (o_gpi !== 32'h1) $display("FAIL run_gpi: got %h exp 1", o_gpi); else n_pass++;
    endtask

    task automatic test_cmd_err();
        send(8'h2A, 23'($urandom));
        n_total++; if (o_gpi !== m_gpi) $display("FAIL err_gpi: got %h exp %h", o_gpi, m_gpi); else n_pass++;
        n_total++; if (o_cmd_err !== m_err) $display("FAIL err_flag: got %b exp %b", o_cmd_err, m_err); else n_pass++;
`ifdef GPIO_CMD_ERR_EN
        n_total++; if (o_gpi !== 32'hFF2A0000) $display("FAIL err_word: got %h exp ff2a0000", o_gpi); else n_pass++;
`endif
        send(8'd1, 23'd1);
        n_total++; if (o_cmd_err !== m_err) $display("FAIL err_sticky: got %b exp %b", o_cmd_err, m_err); else n_pass++;
        send(8'd0, 23'd0);
        n_total++; if (o_cmd_err !== 1'b0) $display("FAIL err_clear: got %b exp 0", o_cmd_err); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0]  op;
        logic [22:0] d;
        int          r;
        for (int k = 0; k < 30; k++) begin
            i_ber_samp_i = {$urandom, $urandom}; i_ber_samp_q = {$urandom, $urandom};
            i_ber_err_i = {$urandom, $urandom};  i_ber_err_q = {$urandom, $urandom};
            i_mem_full = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 15);
            op = (r <= 12) ? 8'(r) : 8'($urandom_range(13, 255));
            d = 23'($urandom);
            send(op, d);
            n_total++; if (o_gpi !== m_gpi) $display("FAIL rnd_gpi op%0d: got %h exp %h", op, o_gpi, m_gpi); else n_pass++;
            n_total++; if ({o_rst, o_enb_tx, o_enb_rx, o_phase_sel} !== {m_rst, m_tx, m_rx, m_ph})
                $display("FAIL rnd_ctrl op%0d: got %b exp %b", op, {o_rst, o_enb_tx, o_enb_rx, o_phase_sel}, {m_rst, m_tx, m_rx, m_ph});
            else n_pass++;
            n_total++; if ({o_read_log, o_addr_log} !== {m_read, m_addr})
                $display("FAIL rnd_mem op%0d: got %h exp %h", op, {o_read_log, o_addr_log}, {m_read, m_addr});
            else n_pass++;
            n_total++; if (o_run_log !== (op == 8'd4)) $display("FAIL rnd_run op%0d: got %b exp %b", op, o_run_log, op == 8'd4); else n_pass++;
            n_total++; if (o_cmd_err !== m_err) $display("FAIL rnd_err op%0d: got %b exp %b", op, o_cmd_err, m_err); else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        logic [14:0] a;
        send(8'd1, 23'd1);
        a = 15'($urandom_range(1, 32767));
        pulse_enable(8'd5, {8'd0, a});
        m_rds++;
        repeat (3) @(posedge clk100);
        @(negedge clk100); i_rst = 1; model_reset();
        @(posedge clk100); @(negedge clk100);
        n_total++; if ({o_enb_tx, o_read_log, o_mem_rd} !== 3'b000) $display("FAIL abort_rst_ctrl: got %b exp 000", {o_enb_tx, o_read_log, o_mem_rd}); else n_pass++;
        n_total++; if (o_addr_log !== 15'h0) $display("FAIL abort_rst_addr: got %h exp 0", o_addr_log); else n_pass++;
        @(negedge clk100); i_rst = 0;
        repeat (8) @(negedge clk100);
        n_total++; if (o_gpi !== 32'h0) $display("FAIL abort_gpi: got %h exp 0", o_gpi); else n_pass++;
        send(8'd11, 23'd0);
        n_total++; if (o_gpi !== 32'h0) $display("FAIL abort_snap: got %h exp 0", o_gpi); else n_pass++;
    endtask

    task automatic test_rst_high_release();
        @(negedge clk100); i_rst = 1; i_gpo = {8'd1, 1'b1, 23'd1}; model_reset();
        repeat (3) @(posedge clk100);
        @(negedge clk100); i_rst = 0;
        repeat (6) @(posedge clk100); @(negedge clk100);
        n_total++; if (o_enb_tx !== 1'b0) $display("FAIL held_enable: got %b exp 0", o_enb_tx); else n_pass++;
        i_gpo[23] = 1'b0;
        send(8'd1, 23'd1);
        n_total++; if (o_enb_tx !== 1'b1) $display("FAIL after_release: got %b exp 1", o_enb_tx); else n_pass++;
    endtask

    task automatic test_counts();
        repeat (4) @(negedge clk100);
        n_total++; if (run_cnt !== m_runs) $display("FAIL run_total: got %0d exp %0d", run_cnt, m_runs); else n_pass++;
        n_total++; if (rd_cnt !== m_rds) $display("FAIL rd_total: got %0d exp %0d", rd_cnt, m_rds); else n_pass++;
    endtask

    initial begin
        i_rst = 1; i_gpo = '0; i_mem_full = 0;
        i_ber_samp_i = '0; i_ber_samp_q = '0; i_ber_err_i = '0; i_ber_err_q = '0;
        model_reset();
        test_reset();
        test_ph_sel_timing();
        test_ber();
        test_read_mem();
        test_drop();
        test_mem_full_run();
        test_cmd_err();
        test_random();
        test_reset_abort();
        test_rst_high_release();
        test_counts();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "timeout");
    end
endmodule
